// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
//  Shared Y86-64 constants for the decode stage:
//   - instruction codes IHALT..IPOPQ
//   - register ids RNONE ("no register") and RRSP (%rsp)
//   - fetch/pipeline status codes SAOK, SHLT, SADR, SINS
//   - field values loaded into the E register for a bubble
//   - usesValP(): instructions whose valA carries the incremented PC
// ---------------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] BUBBLE_ICODE = INOP;
  localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
  localparam logic [2:0] BUBBLE_STAT  = SAOK;

  // jXX and call hand the incremented PC to execute in valA
  function automatic logic usesValP(input logic [3:0] icode);
    logic r;
    case (icode)
      IJXX, ICALL: r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_reg_select.sv
// ---------------------------------------------------------------------------
// decode_reg_select
//  Purely combinational register-id selection for the decode stage.
//  Ports:
//   icode, rA, rB   in  4  fetched icode and register fields
//   srcA, srcB      out 4  register-file read ids (RNONE when unused)
//   dstE, dstM      out 4  destination ids for valE / valM (RNONE when unused)
// ---------------------------------------------------------------------------
module decode_reg_select
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  output logic [3:0] srcA,
  output logic [3:0] srcB,
  output logic [3:0] dstE,
  output logic [3:0] dstM
);

  // Source/destination id decode from icode
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;

    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: srcA = rA;
      IRET, IPOPQ:                    srcA = RRSP;
      default:                        srcA = RNONE;
    endcase

    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         srcB = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     srcB = RRSP;
      default:                        srcB = RNONE;
    endcase

    // cmovXX writes rB unconditionally here; execute cancels it when the condition fails
    case (icode)
      IRRMOVQ, IIRMOVQ, IOPQ:         dstE = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     dstE = RRSP;
      default:                        dstE = RNONE;
    endcase

    case (icode)
      IMRMOVQ, IPOPQ:                 dstM = rA;
      default:                        dstM = RNONE;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//  Y86-64 decode stage plus the D->E pipeline register.
//  Derives srcA/srcB/dstE/dstM, drives the register-file read addresses,
//  selects operand values (with bypass from later stages when enabled),
//  detects data hazards (stallD) and registers the operands for execute.
//
//  Build option DECODE_FWD_EN:
//   defined   - operands forwarded from E/M/W in-flight results; stallD only
//               for a load/use dependency on the instruction in execute.
//   undefined - no bypass; operands come from the register file only and
//               stallD is raised whenever any later stage targets a source.
//
//  Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   dIcode,dIfun,dRA,dRB    fetched instruction fields
//   dValC, dValP, dStat     constant word, incremented PC, fetch status
//   eBubble                 squash request from execute
//   readRegA/B, readDataA/B register-file read port (same-cycle data)
//   ex*/mem*/wb* Dst/Val    in-flight results from later stages
//   stallD                  hold fetch and the D register
//   e*                      registered fields towards execute
// ---------------------------------------------------------------------------
module decode_stage
  import y86_pkg::*;
#(
  parameter int DW = 64
)
(
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    dIcode,
  input  logic [3:0]    dIfun,
  input  logic [3:0]    dRA,
  input  logic [3:0]    dRB,
  input  logic [DW-1:0] dValC,
  input  logic [DW-1:0] dValP,
  input  logic [2:0]    dStat,
  input  logic          eBubble,
  output logic [3:0]    readRegA,
  output logic [3:0]    readRegB,
  input  logic [DW-1:0] readDataA,
  input  logic [DW-1:0] readDataB,
  input  logic [3:0]    exDstE,
  input  logic [DW-1:0] exValE,
  input  logic [3:0]    exDstM,
  input  logic [3:0]    memDstE,
  input  logic [DW-1:0] memValE,
  input  logic [3:0]    memDstM,
  input  logic [DW-1:0] memValM,
  input  logic [3:0]    wbDstE,
  input  logic [DW-1:0] wbValE,
  input  logic [3:0]    wbDstM,
  input  logic [DW-1:0] wbValM,
  output logic          stallD,
  output logic [3:0]    eIcode,
  output logic [3:0]    eIfun,
  output logic [DW-1:0] eValC,
  output logic [DW-1:0] eValA,
  output logic [DW-1:0] eValB,
  output logic [3:0]    eDstE,
  output logic [3:0]    eDstM,
  output logic [3:0]    eSrcA,
  output logic [3:0]    eSrcB,
  output logic [2:0]    eStat
);

  logic [3:0]    srcA;
  logic [3:0]    srcB;
  logic [3:0]    dstE;
  logic [3:0]    dstM;
  logic          srcAUsed;
  logic          srcBUsed;
  logic          hazard;
  logic [DW-1:0] valA;
  logic [DW-1:0] valB;

  decode_reg_select uRegSelect (
    .icode (dIcode),
    .rA    (dRA),
    .rB    (dRB),
    .srcA  (srcA),
    .srcB  (srcB),
    .dstE  (dstE),
    .dstM  (dstM)
  );

  assign readRegA = srcA;
  assign readRegB = srcB;

  // Qualify which source operands really feed execute (jXX/call take valP in valA)
  always_comb begin
    srcAUsed = 1'b0;
    srcBUsed = 1'b0;
    if ((srcA != RNONE) && !usesValP(dIcode)) begin
      srcAUsed = 1'b1;
    end else begin
      srcAUsed = 1'b0;
    end
    if (srcB != RNONE) begin
      srcBUsed = 1'b1;
    end else begin
      srcBUsed = 1'b0;
    end
  end

`ifdef DECODE_FWD_EN
  // Bypass mux: youngest producer wins; memValM ahead of memValE so a popq's
  // loaded value beats its own %rsp update when both name the same register
  function automatic logic [DW-1:0] fwdPick(input logic [3:0] src, input logic [DW-1:0] rd);
    logic [DW-1:0] v;
    if (src == RNONE) begin
      v = {DW{1'b0}};
    end else if (src == exDstE) begin
      v = exValE;
    end else if (src == memDstM) begin
      v = memValM;
    end else if (src == memDstE) begin
      v = memValE;
    end else if (src == wbDstM) begin
      v = wbValM;
    end else if (src == wbDstE) begin
      v = wbValE;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Only a load still in execute cannot be bypassed in time
  always_comb begin
    hazard = 1'b0;
    if (exDstM != RNONE) begin
      hazard = (srcAUsed && (srcA == exDstM)) || (srcBUsed && (srcB == exDstM));
    end else begin
      hazard = 1'b0;
    end
  end
`else
  logic unusedFwdVals;
  assign unusedFwdVals = ^{exValE, memValE, memValM, wbValE, wbValM};

  function automatic logic [DW-1:0] fwdPick(input logic [3:0] src, input logic [DW-1:0] rd);
    logic [DW-1:0] v;
    if (src == RNONE) begin
      v = {DW{1'b0}};
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic inFlight(input logic [3:0] src,
                                    input logic [3:0] d0, input logic [3:0] d1,
                                    input logic [3:0] d2, input logic [3:0] d3,
                                    input logic [3:0] d4, input logic [3:0] d5);
    return (src == d0) || (src == d1) || (src == d2) ||
           (src == d3) || (src == d4) || (src == d5);
  endfunction

  // Without bypass, any pending write to a source register must drain first
  always_comb begin
    hazard = 1'b0;
    if (srcAUsed && inFlight(srcA, exDstE, exDstM, memDstE, memDstM, wbDstE, wbDstM)) begin
      hazard = 1'b1;
    end else if (srcBUsed && inFlight(srcB, exDstE, exDstM, memDstE, memDstM, wbDstE, wbDstM)) begin
      hazard = 1'b1;
    end else begin
      hazard = 1'b0;
    end
  end
`endif

  // Operand selection for execute
  always_comb begin
    valA = {DW{1'b0}};
    valB = {DW{1'b0}};
    if (usesValP(dIcode)) begin
      valA = dValP;
    end else begin
      valA = fwdPick(srcA, readDataA);
    end
    valB = fwdPick(srcB, readDataB);
  end

  // stallD is held low while reset is asserted and follows the inputs after release
  assign stallD = hazard && !reset;

  // D->E pipeline register; bubble on reset, squash or stall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eIcode <= BUBBLE_ICODE;
      eIfun  <= BUBBLE_IFUN;
      eValC  <= {DW{1'b0}};
      eValA  <= {DW{1'b0}};
      eValB  <= {DW{1'b0}};
      eDstE  <= RNONE;
      eDstM  <= RNONE;
      eSrcA  <= RNONE;
      eSrcB  <= RNONE;
      eStat  <= BUBBLE_STAT;
    end else if (eBubble || stallD) begin
      eIcode <= BUBBLE_ICODE;
      eIfun  <= BUBBLE_IFUN;
      eValC  <= {DW{1'b0}};
      eValA  <= {DW{1'b0}};
      eValB  <= {DW{1'b0}};
      eDstE  <= RNONE;
      eDstM  <= RNONE;
      eSrcA  <= RNONE;
      eSrcB  <= RNONE;
      eStat  <= BUBBLE_STAT;
    end else begin
      eIcode <= dIcode;
      eIfun  <= dIfun;
      eValC  <= dValC;
      eValA  <= valA;
      eValB  <= valB;
      eDstE  <= dstE;
      eDstM  <= dstM;
      eSrcA  <= srcA;
      eSrcB  <= srcB;
      eStat  <= dStat;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//  Directed, self-checking bench for decode_stage. Inputs change 1 time unit
//  after a rising edge; combinational outputs are checked 1 unit later and
//  registered outputs 1 unit after the following rising edge.
//  Expectations for the bypass-enabled build are selected with DECODE_FWD_EN.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  dIcode, dIfun, dRA, dRB;
  logic [63:0] dValC, dValP;
  logic [2:0]  dStat;
  logic        eBubble;
  logic [3:0]  readRegA, readRegB;
  logic [63:0] readDataA, readDataB;
  logic [3:0]  exDstE, exDstM, memDstE, memDstM, wbDstE, wbDstM;
  logic [63:0] exValE, memValE, memValM, wbValE, wbValM;
  logic        stallD;
  logic [3:0]  eIcode, eIfun, eDstE, eDstM, eSrcA, eSrcB;
  logic [63:0] eValC, eValA, eValB;
  logic [2:0]  eStat;

  int total = 0;
  int bad   = 0;

  decode_stage #(.DW(64)) dut (
    .clock(clock), .reset(reset),
    .dIcode(dIcode), .dIfun(dIfun), .dRA(dRA), .dRB(dRB),
    .dValC(dValC), .dValP(dValP), .dStat(dStat), .eBubble(eBubble),
    .readRegA(readRegA), .readRegB(readRegB),
    .readDataA(readDataA), .readDataB(readDataB),
    .exDstE(exDstE), .exValE(exValE), .exDstM(exDstM),
    .memDstE(memDstE), .memValE(memValE), .memDstM(memDstM), .memValM(memValM),
    .wbDstE(wbDstE), .wbValE(wbValE), .wbDstM(wbDstM), .wbValM(wbValM),
    .stallD(stallD),
    .eIcode(eIcode), .eIfun(eIfun), .eValC(eValC), .eValA(eValA), .eValB(eValB),
    .eDstE(eDstE), .eDstM(eDstM), .eSrcA(eSrcA), .eSrcB(eSrcB), .eStat(eStat)
  );

  always #5 clock = ~clock;

  task automatic setDefaults();
    dIcode = 4'h1; dIfun = 4'h0; dRA = 4'hF; dRB = 4'hF;
    dValC = 64'h0; dValP = 64'h0; dStat = 3'd1; eBubble = 1'b0;
    readDataA = 64'h0; readDataB = 64'h0;
    exDstE = 4'hF; exDstM = 4'hF; memDstE = 4'hF; memDstM = 4'hF;
    wbDstE = 4'hF; wbDstM = 4'hF;
    exValE = 64'h0; memValE = 64'h0; memValM = 64'h0; wbValE = 64'h0; wbValM = 64'h0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    total++; if (eIcode !== 4'h1) begin bad++; $display("FAIL rst_eIcode got=%0h want=1", eIcode); end
    total++; if (eIfun !== 4'h0) begin bad++; $display("FAIL rst_eIfun got=%0h want=0", eIfun); end
    total++; if ({eValA, eValB, eValC} !== 192'h0) begin bad++; $display("FAIL rst_eVals got=%h/%h/%h want=0", eValA, eValB, eValC); end
    total++; if ({eDstE, eDstM, eSrcA, eSrcB} !== 16'hFFFF) begin bad++; $display("FAIL rst_eRegs got=%h want=ffff", {eDstE, eDstM, eSrcA, eSrcB}); end
    total++; if (eStat !== 3'd1) begin bad++; $display("FAIL rst_eStat got=%0d want=1", eStat); end
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL rst_stallD got=%b want=0", stallD); end
  endtask

  task automatic test_popq_call();
    setDefaults();
    dIcode = 4'hB; dRA = 4'h5; readDataA = 64'h1000; readDataB = 64'h1000;
    #1;
    total++; if (readRegA !== 4'h4) begin bad++; $display("FAIL popq_readRegA got=%0h want=4", readRegA); end
    total++; if (readRegB !== 4'h4) begin bad++; $display("FAIL popq_readRegB got=%0h want=4", readRegB); end
    tick();
    total++; if (eDstE !== 4'h4) begin bad++; $display("FAIL popq_eDstE got=%0h want=4", eDstE); end
    total++; if (eDstM !== 4'h5) begin bad++; $display("FAIL popq_eDstM got=%0h want=5", eDstM); end
    total++; if (eValA !== 64'h1000) begin bad++; $display("FAIL popq_eValA got=%h want=1000", eValA); end
    dIcode = 4'h8; dRA = 4'hF; dRB = 4'hF; dValP = 64'h200; dValC = 64'h300; readDataA = 64'hBAD;
    tick();
    total++; if (eValA !== 64'h200) begin bad++; $display("FAIL call_eValA got=%h want=200", eValA); end
    total++; if (eSrcA !== 4'hF) begin bad++; $display("FAIL call_eSrcA got=%0h want=f", eSrcA); end
    total++; if (eSrcB !== 4'h4 || eDstE !== 4'h4) begin bad++; $display("FAIL call_rsp got=%0h/%0h want=4/4", eSrcB, eDstE); end
    total++; if (eValC !== 64'h300) begin bad++; $display("FAIL call_eValC got=%h want=300", eValC); end
  endtask

  task automatic test_irmovq_rnone();
    setDefaults();
    dIcode = 4'h3; dRB = 4'h7; dValC = 64'h1234; readDataA = 64'hDEAD; readDataB = 64'hBEEF;
    tick();
    total++; if (eIcode !== 4'h3 || eDstE !== 4'h7) begin bad++; $display("FAIL irmov_fields got=%0h/%0h want=3/7", eIcode, eDstE); end
    total++; if (eValA !== 64'h0 || eValB !== 64'h0) begin bad++; $display("FAIL irmov_rnone_zero got=%h/%h want=0/0", eValA, eValB); end
    total++; if (eValC !== 64'h1234) begin bad++; $display("FAIL irmov_eValC got=%h want=1234", eValC); end
  endtask

  task automatic test_forward();
    setDefaults();
    dIcode = 4'h6; dIfun = 4'h1; dRA = 4'h2; dRB = 4'h3;
    readDataA = 64'h22; readDataB = 64'h33;
    exDstE = 4'h3; exValE = 64'h55; memDstE = 4'h3; memValE = 64'h66;
    #1;
`ifdef DECODE_FWD_EN
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL fwd_stallD got=%b want=0", stallD); end
    tick();
    total++; if (eValB !== 64'h55) begin bad++; $display("FAIL fwd_exValE got=%h want=55", eValB); end
    total++; if (eValA !== 64'h22 || eDstE !== 4'h3 || eIfun !== 4'h1) begin bad++; $display("FAIL fwd_fields got=%h/%0h/%0h want=22/3/1", eValA, eDstE, eIfun); end
    exDstE = 4'hF; memDstM = 4'h3; memValM = 64'hB1; memDstE = 4'h3; memValE = 64'hB2;
    wbDstE = 4'h2; wbValE = 64'hC1; wbDstM = 4'h2; wbValM = 64'hC2;
    tick();
    total++; if (eValB !== 64'hB1) begin bad++; $display("FAIL fwd_memM_over_memE got=%h want=b1", eValB); end
    total++; if (eValA !== 64'hC2) begin bad++; $display("FAIL fwd_wbM_over_wbE got=%h want=c2", eValA); end
    memDstM = 4'hF; memDstE = 4'h2; memValE = 64'hD1;
    tick();
    total++; if (eValA !== 64'hD1) begin bad++; $display("FAIL fwd_memE_over_wbM got=%h want=d1", eValA); end
    total++; if (eValB !== 64'h33) begin bad++; $display("FAIL fwd_readData got=%h want=33", eValB); end
`else
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL nofwd_stallD got=%b want=1", stallD); end
    tick();
    total++; if (eIcode !== 4'h1 || eDstE !== 4'hF) begin bad++; $display("FAIL nofwd_bubble got=%0h/%0h want=1/f", eIcode, eDstE); end
    exDstE = 4'hF; memDstE = 4'hF;
    #1;
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL nofwd_release got=%b want=0", stallD); end
    tick();
    total++; if (eValB !== 64'h33 || eValA !== 64'h22) begin bad++; $display("FAIL nofwd_readData got=%h/%h want=33/22", eValB, eValA); end
`endif
  endtask

  task automatic test_load_use();
    setDefaults();
    exDstM = 4'h2; dIcode = 4'h6; dRA = 4'h2; dRB = 4'h3;
    #1;
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL lu_stallD got=%b want=1", stallD); end
    tick();
    total++; if (eIcode !== 4'h1 || eDstE !== 4'hF) begin bad++; $display("FAIL lu_bubble got=%0h/%0h want=1/f", eIcode, eDstE); end
    exDstM = 4'hF; memDstM = 4'h2; memValM = 64'h99; readDataA = 64'h11;
    #1;
`ifdef DECODE_FWD_EN
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL lu_release got=%b want=0", stallD); end
`else
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL lu_memM_stall got=%b want=1", stallD); end
    memDstM = 4'hF; readDataA = 64'h99;
    #1;
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL lu_release got=%b want=0", stallD); end
`endif
    tick();
    total++; if (eValA !== 64'h99 || eIcode !== 4'h6) begin bad++; $display("FAIL lu_eValA got=%h/%0h want=99/6", eValA, eIcode); end
    // jXX reads no registers; call reads %rsp through srcB
    setDefaults();
    dIcode = 4'h7; dRA = 4'h2; exDstM = 4'h2;
    #1;
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL lu_jxx got=%b want=0", stallD); end
    dIcode = 4'h8; exDstM = 4'h4;
    #1;
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL lu_call_rsp got=%b want=1", stallD); end
  endtask

  task automatic test_bubble();
    setDefaults();
    tick();
    eBubble = 1'b1; dIcode = 4'h3; dRB = 4'h7; dValC = 64'h1234;
    #1;
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL bub_stallD got=%b want=0", stallD); end
    tick();
    total++; if (eIcode !== 4'h1 || eDstE !== 4'hF || eValC !== 64'h0) begin bad++; $display("FAIL bub_squash got=%0h/%0h/%h want=1/f/0", eIcode, eDstE, eValC); end
    dIcode = 4'h6; dRA = 4'h2; dRB = 4'h3; exDstM = 4'h2;
    #1;
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL bub_with_stall got=%b want=1", stallD); end
    tick();
    total++; if (eIcode !== 4'h1) begin bad++; $display("FAIL bub_stall_e got=%0h want=1", eIcode); end
  endtask

  task automatic test_stat();
    setDefaults();
    dStat = 3'd4; dIcode = 4'h6; dRA = 4'h1; dRB = 4'h2; readDataA = 64'h7; readDataB = 64'h8;
    tick();
    total++; if (eStat !== 3'd4 || eDstE !== 4'h2 || eValB !== 64'h8) begin bad++; $display("FAIL stat_ins got=%0d/%0h/%h want=4/2/8", eStat, eDstE, eValB); end
    dStat = 3'd2; dIcode = 4'h0;
    tick();
    total++; if (eStat !== 3'd2 || eIcode !== 4'h0) begin bad++; $display("FAIL stat_hlt got=%0d/%0h want=2/0", eStat, eIcode); end
  endtask

  task automatic test_stage_sweep();
    logic expStall;
    for (int k = 0; k < 6; k++) begin
      setDefaults();
      dIcode = 4'h6; dRA = 4'h1; dRB = 4'h3;
      case (k)
        0: exDstE  = 4'h3;
        1: exDstM  = 4'h3;
        2: memDstE = 4'h3;
        3: memDstM = 4'h3;
        4: wbDstE  = 4'h3;
        default: wbDstM = 4'h3;
      endcase
`ifdef DECODE_FWD_EN
      expStall = (k == 1);
`else
      expStall = 1'b1;
`endif
      #1;
      total++; if (stallD !== expStall) begin bad++; $display("FAIL sweep_stage%0d got=%b want=%b", k, stallD, expStall); end
    end
    setDefaults();
    dIcode = 4'h6; dRA = 4'h1; dRB = 4'h3; wbDstE = 4'h3; wbValE = 64'h42; readDataB = 64'h30;
    #1;
`ifdef DECODE_FWD_EN
    tick();
    total++; if (eValB !== 64'h42) begin bad++; $display("FAIL sweep_wbE_fwd got=%h want=42", eValB); end
`else
    wbDstE = 4'hF;
    #1;
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL sweep_drained got=%b want=0", stallD); end
    tick();
    total++; if (eValB !== 64'h30) begin bad++; $display("FAIL sweep_eValB got=%h want=30", eValB); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    setDefaults();
    dIcode = 4'h3; dRB = 4'h7; dValC = 64'h5;
    tick();
    total++; if (eIcode !== 4'h3) begin bad++; $display("FAIL mid_preload got=%0h want=3", eIcode); end
    dIcode = 4'h6; dRA = 4'h2; dRB = 4'h3; exDstM = 4'h2;
    #1;
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL mid_stall got=%b want=1", stallD); end
    reset = 1'b1;
    #1;
    total++; if (eIcode !== 4'h1 || eDstE !== 4'hF || eDstM !== 4'hF || eStat !== 3'd1) begin bad++; $display("FAIL mid_async got=%0h/%0h/%0h/%0d want=1/f/f/1", eIcode, eDstE, eDstM, eStat); end
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL mid_stall_in_reset got=%b want=0", stallD); end
    reset = 1'b0;
    #1;
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL mid_stall_after got=%b want=1", stallD); end
    tick();
    total++; if (eIcode !== 4'h1) begin bad++; $display("FAIL mid_bubble got=%0h want=1", eIcode); end
  endtask

  initial begin
    reset = 1'b1;
    setDefaults();
    #2;
    test_reset();
    tick();
    reset = 1'b0;
    test_popq_call();
    test_irmovq_rnone();
    test_forward();
    test_load_use();
    test_bubble();
    test_stat();
    test_stage_sweep();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
